// File: rtl/alu_mdu.sv
`default_nettype none
// ============================================================================
// Module   : alu_mdu
// Purpose  : MIPS-style ALU with an iterative multiply/divide unit. Single-
//            cycle ALU ops finish one cycle after acceptance; mult/div run
//            one bit per cycle (shift-add / restoring) and update HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       aluop,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [5:0] c_F_ADD   = 6'b100000;
    localparam logic [5:0] c_F_SUB   = 6'b100010;
    localparam logic [5:0] c_F_AND   = 6'b100100;
    localparam logic [5:0] c_F_OR    = 6'b100101;
    localparam logic [5:0] c_F_NOR   = 6'b100111;
    localparam logic [5:0] c_F_SLT   = 6'b101010;
    localparam logic [5:0] c_F_SLTU  = 6'b101011;
    localparam logic [5:0] c_F_MFHI  = 6'b010000;
    localparam logic [5:0] c_F_MFLO  = 6'b010010;
    localparam logic [5:0] c_F_MULT  = 6'b011000;
    localparam logic [5:0] c_F_MULTU = 6'b011001;
    localparam logic [5:0] c_F_DIV   = 6'b011010;
    localparam logic [5:0] c_F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state_q,     w_state_d;
    logic [CNT_W-1:0]     r_cnt_q,       w_cnt_d;
    logic [2*WIDTH-1:0]   r_p_q,         w_p_d;
    logic [WIDTH-1:0]     r_opnd_q,      w_opnd_d;
    logic [WIDTH-1:0]     r_a_q,         w_a_d;
    logic                 r_neg_a_q,     w_neg_a_d;
    logic                 r_neg_b_q,     w_neg_b_d;
    logic                 r_in_ready_q,  w_in_ready_d;
    logic                 r_out_valid_q, w_out_valid_d;
    logic [WIDTH-1:0]     r_result_q,    w_result_d;
    logic                 r_zero_q,      w_zero_d;
    logic                 r_illegal_q,   w_illegal_d;
    logic [WIDTH-1:0]     r_hi_q,        w_hi_d;
    logic [WIDTH-1:0]     r_lo_q,        w_lo_d;

    logic [WIDTH-1:0]     w_alu_res;
    logic                 w_alu_ill;
    logic                 w_is_mul;
    logic                 w_is_div;
    logic                 w_is_signed;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;

    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_p;
    logic [WIDTH:0]       w_rem_sh;
    logic [WIDTH:0]       w_div_diff;
    logic [2*WIDTH-1:0]   w_div_p;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;

    // Decode the request and evaluate every single-cycle operation.
    always_comb begin
        w_alu_res   = '0;
        w_alu_ill   = 1'b0;
        w_is_mul    = 1'b0;
        w_is_div    = 1'b0;
        w_is_signed = 1'b0;
        case (aluop)
            2'b00: w_alu_res = a + b;
            2'b01: w_alu_res = a - b;
            2'b11: w_alu_res = a & b;
            default: begin
                case (funct)
                    c_F_ADD:   w_alu_res = a + b;
                    c_F_SUB:   w_alu_res = a - b;
                    c_F_AND:   w_alu_res = a & b;
                    c_F_OR:    w_alu_res = a | b;
                    c_F_NOR:   w_alu_res = ~(a | b);
                    c_F_SLT:   w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                    c_F_SLTU:  w_alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
                    c_F_MFHI:  w_alu_res = r_hi_q;
                    c_F_MFLO:  w_alu_res = r_lo_q;
                    c_F_MULT:  begin w_is_mul = 1'b1; w_is_signed = 1'b1; end
                    c_F_MULTU: w_is_mul = 1'b1;
                    c_F_DIV:   begin w_is_div = 1'b1; w_is_signed = 1'b1; end
                    c_F_DIVU:  w_is_div = 1'b1;
                    default:   w_alu_ill = 1'b1;
                endcase
            end
        endcase
        // Signed mult/div iterate on magnitudes; signs are re-applied at the end.
        w_a_neg = w_is_signed & a[WIDTH-1];
        w_b_neg = w_is_signed & b[WIDTH-1];
        w_a_mag = w_a_neg ? -a : a;
        w_b_mag = w_b_neg ? -b : b;
    end

    // One iteration step of the shift-add multiplier and the restoring divider.
    always_comb begin
        // Multiplier: low half holds the remaining multiplier bits, product builds from the top.
        w_mul_sum  = {1'b0, r_p_q[2*WIDTH-1:WIDTH]} + ({(WIDTH+1){r_p_q[0]}} & {1'b0, r_opnd_q});
        w_mul_p    = {w_mul_sum, r_p_q[WIDTH-1:1]};
        // Divider: high half is the partial remainder, low half shifts dividend out / quotient in.
        w_rem_sh   = {r_p_q[2*WIDTH-1:WIDTH], r_p_q[WIDTH-1]};
        w_div_diff = w_rem_sh - {1'b0, r_opnd_q};
        if (w_div_diff[WIDTH]) begin
            w_div_p = {w_rem_sh[WIDTH-1:0], r_p_q[WIDTH-2:0], 1'b0};
        end else begin
            w_div_p = {w_div_diff[WIDTH-1:0], r_p_q[WIDTH-2:0], 1'b1};
        end
    end

    // Apply signs and the divide-by-zero override to the final iteration's result.
    always_comb begin
        w_prod = w_mul_p;
        if (r_neg_a_q ^ r_neg_b_q) begin
            w_prod = -w_mul_p;
        end
        w_quo = w_div_p[WIDTH-1:0];
        w_rem = w_div_p[2*WIDTH-1:WIDTH];
        if (r_neg_a_q ^ r_neg_b_q) begin
            w_quo = -w_div_p[WIDTH-1:0];
        end
        if (r_neg_a_q) begin
            w_rem = -w_div_p[2*WIDTH-1:WIDTH];
        end
        if (r_opnd_q == '0) begin
            w_quo = '1;
            w_rem = r_a_q;
        end
    end

    // Next-state and next-output computation for the controller.
    always_comb begin
        w_state_d     = r_state_q;
        w_cnt_d       = r_cnt_q;
        w_p_d         = r_p_q;
        w_opnd_d      = r_opnd_q;
        w_a_d         = r_a_q;
        w_neg_a_d     = r_neg_a_q;
        w_neg_b_d     = r_neg_b_q;
        w_in_ready_d  = r_in_ready_q;
        w_out_valid_d = r_out_valid_q;
        w_result_d    = r_result_q;
        w_zero_d      = r_zero_q;
        w_illegal_d   = r_illegal_q;
        w_hi_d        = r_hi_q;
        w_lo_d        = r_lo_q;
        case (r_state_q)
            S_IDLE: begin
                if (in_valid && r_in_ready_q) begin
                    w_in_ready_d = 1'b0;
                    w_a_d        = a;
                    w_neg_a_d    = w_a_neg;
                    w_neg_b_d    = w_b_neg;
                    w_cnt_d      = '0;
                    if (w_is_mul) begin
                        w_p_d     = {{WIDTH{1'b0}}, w_b_mag};
                        w_opnd_d  = w_a_mag;
                        w_state_d = S_MUL;
                    end else if (w_is_div) begin
                        w_p_d     = {{WIDTH{1'b0}}, w_a_mag};
                        w_opnd_d  = w_b_mag;
                        w_state_d = S_DIV;
                    end else begin
                        w_result_d    = w_alu_res;
                        w_zero_d      = (w_alu_res == '0);
                        w_illegal_d   = w_alu_ill;
                        w_out_valid_d = 1'b1;
                        w_state_d     = S_DONE;
                    end
                end
            end
            S_MUL: begin
                w_p_d   = w_mul_p;
                w_cnt_d = r_cnt_q + 1'b1;
                if (r_cnt_q == c_CNT_LAST) begin
                    w_cnt_d       = '0;
                    w_hi_d        = w_prod[2*WIDTH-1:WIDTH];
                    w_lo_d        = w_prod[WIDTH-1:0];
                    w_result_d    = w_prod[WIDTH-1:0];
                    w_zero_d      = (w_prod[WIDTH-1:0] == '0);
                    w_illegal_d   = 1'b0;
                    w_out_valid_d = 1'b1;
                    w_state_d     = S_DONE;
                end
            end
            S_DIV: begin
                w_p_d   = w_div_p;
                w_cnt_d = r_cnt_q + 1'b1;
                if (r_cnt_q == c_CNT_LAST) begin
                    w_cnt_d       = '0;
                    w_hi_d        = w_rem;
                    w_lo_d        = w_quo;
                    w_result_d    = w_quo;
                    w_zero_d      = (w_quo == '0);
                    w_illegal_d   = 1'b0;
                    w_out_valid_d = 1'b1;
                    w_state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_out_valid_d = 1'b0;
                    w_in_ready_d  = 1'b1;
                    w_state_d     = S_IDLE;
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q     <= S_IDLE;
            r_cnt_q       <= '0;
            r_p_q         <= '0;
            r_opnd_q      <= '0;
            r_a_q         <= '0;
            r_neg_a_q     <= 1'b0;
            r_neg_b_q     <= 1'b0;
            r_in_ready_q  <= 1'b1;
            r_out_valid_q <= 1'b0;
            r_result_q    <= '0;
            r_zero_q      <= 1'b1;
            r_illegal_q   <= 1'b0;
            r_hi_q        <= '0;
            r_lo_q        <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_cnt_q       <= w_cnt_d;
            r_p_q         <= w_p_d;
            r_opnd_q      <= w_opnd_d;
            r_a_q         <= w_a_d;
            r_neg_a_q     <= w_neg_a_d;
            r_neg_b_q     <= w_neg_b_d;
            r_in_ready_q  <= w_in_ready_d;
            r_out_valid_q <= w_out_valid_d;
            r_result_q    <= w_result_d;
            r_zero_q      <= w_zero_d;
            r_illegal_q   <= w_illegal_d;
            r_hi_q        <= w_hi_d;
            r_lo_q        <= w_lo_d;
        end
    end

    assign in_ready  = r_in_ready_q;
    assign out_valid = r_out_valid_q;
    assign result    = r_result_q;
    assign zero      = r_zero_q;
    assign illegal   = r_illegal_q;
    assign hi        = r_hi_q;
    assign lo        = r_lo_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_mdu.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mdu
// Purpose  : Scoreboard bench for alu_mdu (WIDTH=32) with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mdu;

    localparam int W  = 32;
    localparam int L1 = 1;
    localparam int LM = W + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    aluop = 2'b00;
    logic [5:0]    funct = 6'b000000;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  result;
    logic          zero;
    logic          illegal;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         ill;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    alu_mdu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluop     (aluop),
        .funct     (funct),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on each handshake, checks latency and hold stability.
    logic         ov_prev = 1'b0;
    logic         hold_pending = 1'b0;
    logic [W-1:0] held_res;
    logic         held_z;
    logic         held_ill;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL in_ready_while_busy: in_ready=%b required 0", in_ready);
                end
                if (sb.size() == 0) begin
                    if (!ov_prev) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out_valid: result=%h with no request outstanding", result);
                    end
                end else begin
                    if (!ov_prev) begin
                        checks++;
                        if (cyc != sb[0].cyc) begin
                            errors++;
                            $display("FAIL %s_latency: out_valid at cycle %0d required %0d", sb[0].name, cyc, sb[0].cyc);
                        end
                    end
                    if (hold_pending) begin
                        checks++;
                        if (result !== held_res || zero !== held_z || illegal !== held_ill) begin
                            errors++;
                            $display("FAIL %s_hold_stable: res=%h z=%b ill=%b required res=%h z=%b ill=%b",
                                     sb[0].name, result, zero, illegal, held_res, held_z, held_ill);
                        end
                    end
                    if (out_ready) begin
                        e = sb.pop_front();
                        checks++;
                        if (result !== e.res || zero !== e.z || illegal !== e.ill || hi !== e.hi || lo !== e.lo) begin
                            errors++;
                            $display("FAIL %s: got res=%h z=%b ill=%b hi=%h lo=%h required res=%h z=%b ill=%b hi=%h lo=%h",
                                     e.name, result, zero, illegal, hi, lo, e.res, e.z, e.ill, e.hi, e.lo);
                        end
                    end
                end
            end
            hold_pending = out_valid && !out_ready;
            held_res     = result;
            held_z       = zero;
            held_ill     = illegal;
        end else begin
            hold_pending = 1'b0;
        end
        ov_prev = out_valid;
    end

    task automatic chk32(input string nm, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, got, want);
        end
    endtask

    task automatic chk1(input string nm, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b required %b", nm, got, want);
        end
    endtask

    // Present one request, push its expected response, drop in_valid after acceptance.
    task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                         input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [W-1:0] er, input logic eill,
                         input logic [W-1:0] ehi, input logic [W-1:0] elo,
                         input int lat, input string nm);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_accept_timeout: in_ready=%b required 1", nm, in_ready);
            return;
        end
        aluop    = op;
        funct    = fn;
        a        = ia;
        b        = ib;
        in_valid = 1'b1;
        e.res  = er;
        e.z    = (er == '0);
        e.ill  = eill;
        e.hi   = ehi;
        e.lo   = elo;
        e.cyc  = cyc + lat;
        e.name = nm;
        sb.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk1 ("reset_in_ready",  in_ready,  1'b1);
        chk1 ("reset_out_valid", out_valid, 1'b0);
        chk32("reset_result",    result,    32'h0);
        chk1 ("reset_zero",      zero,      1'b1);
        chk1 ("reset_illegal",   illegal,   1'b0);
        chk32("reset_hi",        hi,        32'h0);
        chk32("reset_lo",        lo,        32'h0);

        // Single-cycle operations (HI/LO still zero).
        issue(2'b10, 6'b100010, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 32'h0, 32'h0, L1, "rsub_5_7");       wait_drain();
        issue(2'b00, 6'b000000, 32'hFFFFFFFF, 32'd1,        32'h00000000, 1'b0, 32'h0, 32'h0, L1, "add_wrap");       wait_drain();
        issue(2'b01, 6'b000000, 32'd10,       32'd3,        32'd7,        1'b0, 32'h0, 32'h0, L1, "sub_10_3");       wait_drain();
        issue(2'b11, 6'b000000, 32'h0000F0F0, 32'h00000FF0, 32'h000000F0, 1'b0, 32'h0, 32'h0, L1, "and");            wait_drain();
        issue(2'b10, 6'b100101, 32'h00000F00, 32'h000000F0, 32'h00000FF0, 1'b0, 32'h0, 32'h0, L1, "or");             wait_drain();
        issue(2'b10, 6'b100111, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, 32'h0, 32'h0, L1, "nor");            wait_drain();
        issue(2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 32'h0, 32'h0, L1, "slt_neg");        wait_drain();
        issue(2'b10, 6'b101011, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 32'h0, 32'h0, L1, "sltu_big");       wait_drain();
        issue(2'b10, 6'b100000, 32'd3,        32'd4,        32'd7,        1'b0, 32'h0, 32'h0, L1, "radd_3_4");       wait_drain();

        // Multiply, then read back HI/LO.
        issue(2'b10, 6'b011000, 32'hFFFFFFFF, 32'd3,        32'hFFFFFFFD, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, LM, "mult_m1_3"); wait_drain();
        issue(2'b10, 6'b010000, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, L1, "mfhi");      wait_drain();
        issue(2'b10, 6'b010010, 32'h0,        32'h0,        32'hFFFFFFFD, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, L1, "mflo");      wait_drain();
        issue(2'b10, 6'b011001, 32'hFFFFFFFF, 32'd3,        32'hFFFFFFFD, 1'b0, 32'h00000002, 32'hFFFFFFFD, LM, "multu_max_3"); wait_drain();

        // Divides, including divide-by-zero and the signed overflow case.
        issue(2'b10, 6'b011010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, LM, "div_m7_2");   wait_drain();
        issue(2'b10, 6'b011011, 32'd9,        32'd0,        32'hFFFFFFFF, 1'b0, 32'h00000009, 32'hFFFFFFFF, LM, "divu_by_0");  wait_drain();
        issue(2'b10, 6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 32'h00000000, 32'h80000000, LM, "div_min_m1"); wait_drain();
        issue(2'b10, 6'b011010, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 32'h00000001, 32'hFFFFFFFD, LM, "div_7_m2");   wait_drain();
        issue(2'b10, 6'b011011, 32'd100,      32'd7,        32'd14,       1'b0, 32'h00000002, 32'd14,       LM, "divu_100_7"); wait_drain();
        issue(2'b10, 6'b011001, 32'h12345678, 32'h10,       32'h23456780, 1'b0, 32'h00000001, 32'h23456780, LM, "multu_shift"); wait_drain();

        // Unsupported funct leaves HI/LO alone; funct is ignored for aluop 00.
        issue(2'b10, 6'b111111, 32'd5,        32'd6,        32'h0,        1'b1, 32'h00000001, 32'h23456780, L1, "illegal_funct"); wait_drain();
        issue(2'b00, 6'b111111, 32'd1,        32'd1,        32'd2,        1'b0, 32'h00000001, 32'h23456780, L1, "add_ign_funct"); wait_drain();

        // Backpressure: result held, new request ignored, release returns to IDLE.
        @(posedge clk);
        #1 out_ready = 1'b0;
        issue(2'b00, 6'b000000, 32'd2, 32'd3, 32'd5, 1'b0, 32'h00000001, 32'h23456780, L1, "hold_add");
        aluop    = 2'b01;
        a        = 32'd100;
        b        = 32'd1;
        in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1 in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk1("hold_release_in_ready",  in_ready,  1'b1);
        chk1("hold_release_out_valid", out_valid, 1'b0);
        wait_drain();

        // Reset in the middle of a divide aborts it and clears HI/LO.
        issue(2'b10, 6'b011011, 32'd100, 32'd7, 32'd14, 1'b0, 32'd2, 32'd14, LM, "div_aborted");
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk1 ("abort_in_ready",  in_ready,  1'b1);
        chk1 ("abort_out_valid", out_valid, 1'b0);
        chk32("abort_hi",        hi,        32'h0);
        chk32("abort_lo",        lo,        32'h0);
        repeat (W + 8) @(negedge clk);
        issue(2'b10, 6'b010000, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, L1, "mfhi_after_abort"); wait_drain();

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
